// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// Carries the instruction fields and status that the datapath supplies, and the selects and enables it receives.
// Purely structural; there is no storage and no flow control of its own.
interface multicycle_ctrl_if;
    // datapath -> controller
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    // controller -> datapath
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    // Controller side
    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
        output irwrite, pcwrite, regwrite, memwrite, instr_done, illegal, state
    );

    // Datapath side
    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
        input  irwrite, pcwrite, regwrite, memwrite, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle X-RISC control sequencer: fetch/decode/execute/memory/writeback FSM with a trap for unsupported opcodes.
// Latency (mem_ready high): lw 5, sw 4, R/I 4, beq 3 cycles; selects and enables are combinational from the current state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; write enables drop as soon as reset_n falls.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_SUB = 2'b01,
        ALUOP_FN  = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // An out-of-range reset parameter falls back to FETCH rather than an undefined encoding.
    localparam state_t RST_ST = (RESET_STATE <= 4'd10) ? state_t'(RESET_STATE) : S_FETCH;

    state_t     state_q, state_d;
    aluop_t     aluop;
    logic [1:0] alusrca_c, alusrcb_c, resultsrc_c;
    logic       adrsrc_c;
    logic       irwrite_c, pcwrite_c, regwrite_c, memwrite_c, done_c, illegal_c;
    logic [2:0] alucontrol_c;

    // State register; reset lands in FETCH immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_ST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state selects/enables.
    always_comb begin
        state_d     = state_q;
        aluop       = ALUOP_ADD;
        alusrca_c   = 2'b00;
        alusrcb_c   = 2'b00;
        resultsrc_c = 2'b00;
        adrsrc_c    = 1'b0;
        irwrite_c   = 1'b0;
        pcwrite_c   = 1'b0;
        regwrite_c  = 1'b0;
        memwrite_c  = 1'b0;
        done_c      = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 computed while the instruction word is read; both latch only on the ready cycle.
                alusrcb_c   = 2'b10;
                resultsrc_c = 2'b10;
                irwrite_c   = bus.mem_ready;
                pcwrite_c   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is precomputed here for BEQ.
                alusrca_c = 2'b01;
                alusrcb_c = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 2'b10;
                alusrcb_c = 2'b01;
                state_d   = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc_c = 2'b01;
                regwrite_c  = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                // Store strobe stays asserted for the whole stall; retire on the accepting cycle.
                adrsrc_c   = 1'b1;
                memwrite_c = 1'b1;
                done_c     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alusrca_c = 2'b10;
                aluop     = ALUOP_FN;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alusrca_c = 2'b10;
                alusrcb_c = 2'b01;
                aluop     = ALUOP_FN;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alusrca_c = 2'b10;
                aluop     = ALUOP_SUB;
                pcwrite_c = bus.zero;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                // Corrupted encodings are treated like an unsupported opcode.
                state_d = S_TRAP;
            end
        endcase
    end

    // ALU operation from the op class; subtract for R-type only when funct7b5 is set.
    always_comb begin
        alucontrol_c = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol_c = ALU_SUB;
            ALUOP_FN: begin
                case (bus.funct3)
                    3'b000:  alucontrol_c = (bus.funct7b5 & bus.op[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_c = ALU_SLT;
                    3'b110:  alucontrol_c = ALU_OR;
                    3'b111:  alucontrol_c = ALU_AND;
                    default: alucontrol_c = ALU_ADD;
                endcase
            end
            default: alucontrol_c = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state.
    assign bus.immsrc = (bus.op == OP_SW)  ? 2'b01 :
                        (bus.op == OP_BEQ) ? 2'b10 : 2'b00;

    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.alucontrol = alucontrol_c;
    assign bus.resultsrc  = resultsrc_c;
    assign bus.adrsrc     = adrsrc_c;
    assign bus.state      = state_q;

    // Enables are masked by reset_n so no architectural write can leak while reset is held.
    assign bus.irwrite    = irwrite_c  & reset_n;
    assign bus.pcwrite    = pcwrite_c  & reset_n;
    assign bus.regwrite   = regwrite_c & reset_n;
    assign bus.memwrite   = memwrite_c & reset_n;
    assign bus.instr_done = done_c     & reset_n;
    assign bus.illegal    = illegal_c  & reset_n;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control sequencer for the multicycle X-RISC core. It steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the extend unit's immsrc select, the ALU operand/operation selects and all architectural write enables. Memory accesses are stalled by a ready handshake. Opcodes the extend unit cannot serve (J/U types) are trapped.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must be a legal encoding.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0]; valid from DECODE onward (IR already latched)
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- immsrc  out  2  to extend unit: 00 I, 01 S, 10 B
- alusrca  out  2  00 PC, 01 OldPC, 10 rs1
- alusrcb  out  2  00 rs2, 01 immext, 10 const 4
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- adrsrc  out  1  0 PC, 1 Result
- irwrite, pcwrite, regwrite, memwrite  out  1 each  enables
- instr_done  out  1  one-cycle retire pulse
- illegal  out  1  high while in TRAP
- state  out  4  current state (debug)

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, TRAP 10.
- Reset: asynchronous; state=FETCH. While reset_n=0, force irwrite, pcwrite, regwrite, memwrite, instr_done and illegal to 0. All other outputs take their FETCH values.
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011.
- Transitions:
  - FETCH->DECODE on mem_ready; hold otherwise.
  - DECODE: lw/sw->MEMADR; R->EXECR; I->EXECI; beq->BEQ; any other->TRAP.
  - MEMADR: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD->MEMWB on mem_ready, else hold.
  - MEMWRITE->FETCH on mem_ready, else hold.
  - MEMWB, ALUWB, BEQ->FETCH.
  - EXECR, EXECI->ALUWB.
  - TRAP is absorbing until reset.
  - Illegal encodings 11-15 go to TRAP.
- immsrc: combinational from op in every state. sw 01, beq 10, others 00.
- ALU op class aluop:
  - 00 in FETCH, DECODE, MEMADR -> add.
  - 01 in BEQ -> sub.
  - 10 in EXECR/EXECI -> funct3 decode:
    - 000: add, or sub if funct7b5&op[5].
    - 010: slt.
    - 110: or.
    - 111: and.
    - other: add.
- Per-state outputs (unlisted selects = 00, enables = 0):
  - FETCH: alusrcb=10, resultsrc=10, adrsrc=0; irwrite=pcwrite=mem_ready.
  - DECODE: alusrca=01, alusrcb=01 (branch target).
  - MEMADR: alusrca=10, alusrcb=01.
  - MEMREAD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1, instr_done=1.
  - MEMWRITE: adrsrc=1, memwrite=1 held every cycle until mem_ready; instr_done=mem_ready.
  - EXECR: alusrca=10.
  - EXECI: alusrca=10, alusrcb=01.
  - ALUWB: regwrite=1, instr_done=1.
  - BEQ: alusrca=10, pcwrite=zero, instr_done=1.
  - TRAP: illegal=1, all enables 0.
- Latency with mem_ready tied high: lw 5 cycles, sw 4, R/I 4, beq 3.
- Stall in FETCH: irwrite and pcwrite fire exactly once, in the mem_ready cycle.
- Reset asserted mid-instruction: pending write enables drop immediately. No partial write is required to complete.

Test Plan:
- mem_ready=1, op=0000011: state 0->1->2->3->4->0; immsrc=00; regwrite only in state 4; instr_done single pulse.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE: memwrite high 4 cycles, state stays 5, instr_done in the ready cycle; immsrc=01.
- op=0110011, funct3=000, funct7b5=1: alucontrol=001 in EXECR. Repeat with op=0010011: alucontrol=000 (add). funct3=110 gives 011.
- op=1100011: immsrc=10 in DECODE. zero=1 gives pcwrite=1 in BEQ; zero=0 gives pcwrite=0; next state FETCH.
- op=1101111 (jal): DECODE->TRAP, illegal=1 for 20 cycles, no enables. reset_n pulse returns to FETCH.
- reset_n low in MEMWRITE with memwrite high: memwrite falls without a clock edge, state=0. FETCH with mem_ready=0 for 2 cycles gives irwrite=0 until the ready cycle.
